alu_mdu: RTL and testbench

- Parametrised-width MIPS-style ALU with an iterative multiply/divide unit (MDU) and architectural HI/LO registers.
- Single-cycle ops (logic, add/sub, slt, shifts, mfhi/mflo) are combinational.
- MULT/MULTU/DIV/DIVU run as a multicycle FSM under a start/busy/done handshake.
- Sits in the datapath execute stage; the controller stalls on busy.

---
 rtl/alu_mdu.sv | 97 +++++++++
 tb/tb_alu_mdu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: MIPS-style ALU with iterative multiply/divide and HI/LO; define MDU_EARLY_OUT_EN for multiply early-out
module alu_mdu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       alucontrol,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] acc, mc, prod;
    logic [WIDTH-1:0] mp, aa, bb, rem, quo;
    logic [WIDTH:0] r_sh, diff;
    logic [SHW-1:0] cnt;
    logic is_div, dz, neg_lo, neg_hi, sg, launch, last;
    always_comb begin
        result = '0;
        case (alucontrol)
            4'b0000: result = a & b;
            4'b0001: result = a | b;
            4'b0010: result = a + b;
            4'b0110: result = a - b;
            4'b0111: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: result = b << shamt;
            4'b1001: result = b >> shamt;
            4'b1010: result = $signed(b) >>> shamt;
            4'b0100: result = hi;
            4'b0101: result = lo;
            default: result = '0;
        endcase
    end
    assign zero   = result == '0;
    assign busy   = state != IDLE;
    assign launch = start && alucontrol[3:2] == 2'b11 && state == IDLE;
    assign sg     = ~alucontrol[0];
    assign aa     = sg && a[WIDTH-1] ? -a : a;
    assign bb     = sg && b[WIDTH-1] ? -b : b;
    // restoring divide: mp holds dividend shifting into remainder (acc low half), quotient bits shift into mp
    assign r_sh   = {acc[WIDTH-1:0], mp[WIDTH-1]};
    assign diff   = r_sh - {1'b0, mc[WIDTH-1:0]};
    assign prod   = neg_lo ? -acc : acc;
    assign rem    = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign quo    = dz ? '1 : neg_lo ? -mp : mp;
`ifdef MDU_EARLY_OUT_EN
    assign last   = cnt == SHW'(WIDTH-1) || (!is_div && mp[WIDTH-1:1] == '0);
`else
    assign last   = cnt == SHW'(WIDTH-1);
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state == IDLE ? (launch ? RUN : IDLE) : state == RUN ? (last ? FIX : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {acc, mc, mp, cnt, is_div, dz, neg_lo, neg_hi, done, hi, lo} <= '0;
        end else begin
            done <= state == FIX;
            if (launch) begin
                is_div <= alucontrol[1];
                dz     <= b == '0;
                neg_lo <= sg & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi <= sg & (alucontrol[1] ? a[WIDTH-1] : a[WIDTH-1] ^ b[WIDTH-1]);
                acc    <= '0;
                cnt    <= '0;
                mc     <= {{WIDTH{1'b0}}, alucontrol[1] ? bb : aa};
                mp     <= alucontrol[1] ? aa : bb;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    acc[WIDTH-1:0] <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    mp <= {mp[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    acc <= acc + (mp[0] ? mc : '0);
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                end
            end else if (state == FIX) begin
                hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
                lo <= is_div ? quo : prod[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH=32
module tb_alu_mdu;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [4:0] shamt = '0;
    logic [3:0] alucontrol = '0;
    logic [31:0] result, hi, lo;
    logic zero, busy, done;
    int checks = 0, errors = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .shamt(shamt), .alucontrol(alucontrol),
        .start(start), .result(result), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic run_mdu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        alucontrol = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h5A5A5A5A; alucontrol = 4'b0000;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start op=%b: got %b want 1", op, busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_timeout op=%b: done never asserted", op); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_with_done op=%b: got %b want 0", op, busy); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== '0) begin
            errors++; $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        logic [3:0]  ops [10] = '{4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1001, 4'b0000, 4'b0001, 4'b0010, 4'b1100, 4'b0011};
        logic [31:0] va  [10] = '{32'd5, 32'hFFFFFFFF, 32'd9, 32'd0, 32'd0, 32'hF0, 32'hF0, 32'hFFFFFFFF, 32'd6, 32'd6};
        logic [31:0] vb  [10] = '{32'd7, 32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'h0F, 32'h0F, 32'd1, 32'd3, 32'd3};
        logic [4:0]  vs  [10] = '{5'd0, 5'd0, 5'd31, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] ve  [10] = '{32'hFFFFFFFE, 32'd1, 32'h80000000, 32'hF8000000, 32'h08000000, 32'd0, 32'hFF, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            alucontrol = ops[i]; a = va[i]; b = vb[i]; shamt = vs[i];
            #1;
            checks++;
            if (result !== ve[i] || zero !== (ve[i] == 0)) begin
                errors++;
                $display("FAIL alu_op_%b: result=%h zero=%b want result=%h zero=%b", ops[i], result, zero, ve[i], ve[i] == 0);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mdu_code_without_start: busy=%b want 0", busy); end
    endtask

    task automatic test_mult;
        int lat;
        run_mdu(4'b1100, -32'sd3, 32'd7, lat);
        checks++;
        if (lat !== (EO ? 4 : 33)) begin errors++; $display("FAIL mult_latency: got %0d want %0d", lat, EO ? 4 : 33); end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL mult_neg3x7: hi=%h lo=%h want FFFFFFFF FFFFFFEB", hi, lo);
        end
        @(negedge clk);
        alucontrol = 4'b0101;
        #1;
        checks++;
        if (result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mflo: got %h want FFFFFFEB", result); end
    endtask

    task automatic test_mdu_table;
        logic [3:0]  ops [7] = '{4'b1110, 4'b1111, 4'b1110, 4'b1110, 4'b1101, 4'b1111, 4'b1100};
        logic [31:0] va  [7] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9, 32'd5, 32'd100, 32'h80000000};
        logic [31:0] vb  [7] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd7, 32'h80000000};
        logic [31:0] eh  [7] = '{32'hFFFFFFFF, 32'd7, 32'd0, 32'hFFFFFFF9, 32'd0, 32'd2, 32'h40000000};
        logic [31:0] el  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'd14, 32'd0};
        int          et  [7] = '{33, 33, 33, 33, EO ? 2 : 33, 33, 33};
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_mdu(ops[i], va[i], vb[i], lat);
            checks++;
            if (hi !== eh[i] || lo !== el[i]) begin
                errors++; $display("FAIL mdu_%0d_op_%b: hi=%h lo=%h want %h %h", i, ops[i], hi, lo, eh[i], el[i]);
            end
            checks++;
            if (lat !== et[i]) begin errors++; $display("FAIL mdu_%0d_latency: got %0d want %0d", i, lat, et[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int ndone = 0, tdone = 0;
        @(negedge clk);
        alucontrol = 4'b1101; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; alucontrol = 4'b0100; a = 32'd1; b = 32'd1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin ndone++; tdone = c; end
            if (c == 5) begin
                checks++;
                if (result !== 32'h40000000) begin errors++; $display("FAIL mfhi_while_busy: got %h want 40000000", result); end
            end
            if (c == 10) begin alucontrol = 4'b1101; a = 32'd2; b = 32'd2; start = 1'b1; end
            if (c == 11) begin start = 1'b0; alucontrol = 4'b0100; end
        end
        checks++;
        if (ndone !== 1 || tdone !== 33) begin errors++; $display("FAIL done_once: count=%0d at=%0d want 1 at 33", ndone, tdone); end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++; $display("FAIL multu_max: hi=%h lo=%h want FFFFFFFE 00000001", hi, lo);
        end
        @(negedge clk);
        alucontrol = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_non_mdu: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midop;
        int ndone = 0, lat;
        @(negedge clk);
        alucontrol = 4'b1111; a = 32'd100; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_midop: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL no_done_after_reset: count=%0d want 0", ndone); end
        run_mdu(4'b1101, 32'd3, 32'd4, lat);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd12) begin errors++; $display("FAIL multu_after_reset: hi=%h lo=%h want 0 C", hi, lo); end
        checks++;
        if (lat !== (EO ? 4 : 33)) begin errors++; $display("FAIL multu_after_reset_latency: got %0d want %0d", lat, EO ? 4 : 33); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mult;
        test_mdu_table;
        test_back_to_back;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
